// File: rtl/axis_rr_arbiter.sv
// Packet-level AXI-Stream arbiter: N requesters share one registered master stream.
// Define AXIS_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module axis_rr_arbiter #(
   parameter int  N_PORTS = 4,
   parameter int  DATA_W  = 32,
   parameter int  USER_W  = 2,
   localparam int KEEP_W  = DATA_W / 8,
   localparam int PTR_W   = $clog2(N_PORTS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_PORTS-1:0]          s_tvalid,
   input  logic [N_PORTS*DATA_W-1:0]   s_tdata,
   input  logic [N_PORTS*KEEP_W-1:0]   s_tstrb,
   input  logic [N_PORTS*KEEP_W-1:0]   s_tkeep,
   input  logic [N_PORTS*USER_W-1:0]   s_tuser,
   input  logic [N_PORTS-1:0]          s_tlast,
   output logic [N_PORTS-1:0]          s_tready,
   output logic                        m_tvalid,
   output logic [DATA_W-1:0]           m_tdata,
   output logic [KEEP_W-1:0]           m_tstrb,
   output logic [KEEP_W-1:0]           m_tkeep,
   output logic [USER_W-1:0]           m_tuser,
   output logic                        m_tlast,
   input  logic                        m_tready,
   output logic [PTR_W-1:0]            grant_id,
   output logic                        busy
);

   // Handshake: a beat moves when valid and ready are both high on a rising clk edge;
   // valid never waits on ready, and the output stage accepts while empty or unloading.
   typedef enum logic {ARB_IDLE = 1'b0, ARB_PASS = 1'b1} arb_state_e;

   arb_state_e           state_q, state_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]     grant_q, grant_d;
   logic [PTR_W-1:0]     win_idx;
   logic [PTR_W-1:0]     ptr_next;
   logic                 win_found;
   logic                 accept;
   logic [N_PORTS-1:0]   ready_c;
   int                   idx;

   logic                 m_tvalid_q, m_tvalid_d;
   logic [DATA_W-1:0]    m_tdata_q,  m_tdata_d;
   logic [KEEP_W-1:0]    m_tstrb_q,  m_tstrb_d;
   logic [KEEP_W-1:0]    m_tkeep_q,  m_tkeep_d;
   logic [USER_W-1:0]    m_tuser_q,  m_tuser_d;
   logic                 m_tlast_q,  m_tlast_d;

   // Upward search from rr_ptr with wrap; in fixed-priority builds rr_ptr stays 0.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 0; k < N_PORTS; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= N_PORTS) idx = idx - N_PORTS;
         if (!win_found && s_tvalid[idx]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(idx);
         end
      end
   end

   assign ptr_next = (grant_q == PTR_W'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      ready_c  = '0;
      accept   = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (win_found) begin
               grant_d = win_idx;
               state_d = ARB_PASS;
            end
         end
         ARB_PASS: begin
            ready_c[grant_q] = ~m_tvalid_q | m_tready;
            accept           = ready_c[grant_q] & s_tvalid[grant_q];
            if (accept && s_tlast[grant_q]) begin
               state_d = ARB_IDLE;
`ifdef AXIS_ARB_FIXED_PRIO_EN
               rr_ptr_d = '0;
`else
               rr_ptr_d = ptr_next;
`endif
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Single-entry output stage; load and unload may happen in the same cycle.
   always_comb begin
      m_tvalid_d = m_tvalid_q;
      m_tdata_d  = m_tdata_q;
      m_tstrb_d  = m_tstrb_q;
      m_tkeep_d  = m_tkeep_q;
      m_tuser_d  = m_tuser_q;
      m_tlast_d  = m_tlast_q;
      if (accept) begin
         m_tvalid_d = 1'b1;
         m_tdata_d  = s_tdata[int'(grant_q)*DATA_W +: DATA_W];
         m_tstrb_d  = s_tstrb[int'(grant_q)*KEEP_W +: KEEP_W];
         m_tkeep_d  = s_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
         m_tuser_d  = s_tuser[int'(grant_q)*USER_W +: USER_W];
         m_tlast_d  = s_tlast[grant_q];
      end else if (m_tready) begin
         m_tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB_IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tstrb_q  <= '0;
         m_tkeep_q  <= '0;
         m_tuser_q  <= '0;
         m_tlast_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         m_tvalid_q <= m_tvalid_d;
         m_tdata_q  <= m_tdata_d;
         m_tstrb_q  <= m_tstrb_d;
         m_tkeep_q  <= m_tkeep_d;
         m_tuser_q  <= m_tuser_d;
         m_tlast_q  <= m_tlast_d;
      end
   end

   assign s_tready = ready_c;
   assign m_tvalid = m_tvalid_q;
   assign m_tdata  = m_tdata_q;
   assign m_tstrb  = m_tstrb_q;
   assign m_tkeep  = m_tkeep_q;
   assign m_tuser  = m_tuser_q;
   assign m_tlast  = m_tlast_q;
   assign grant_id = grant_q;
   assign busy     = (state_q == ARB_PASS) | m_tvalid_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomized and directed bench for axis_rr_arbiter against a packet-rule reference model.
// Build with AXIS_ARB_FIXED_PRIO_EN to exercise the fixed-priority variant.
module tb_axis_rr_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int UW = 2;
   localparam int KW = DW / 8;
   localparam int PW = 2;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_drv = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    s_tvalid = '0, s_tlast = '0, s_tready;
   logic [N*DW-1:0] s_tdata = '0;
   logic [N*KW-1:0] s_tstrb = '0, s_tkeep = '0;
   logic [N*UW-1:0] s_tuser = '0;
   logic            m_tvalid, m_tlast, busy;
   logic            m_tready = 1'b0;
   logic [DW-1:0]   m_tdata;
   logic [KW-1:0]   m_tstrb, m_tkeep;
   logic [UW-1:0]   m_tuser;
   logic [PW-1:0]   grant_id;

   axis_rr_arbiter #(.N_PORTS(N), .DATA_W(DW), .USER_W(UW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tkeep(s_tkeep),
      .s_tuser(s_tuser), .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep),
      .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tready(m_tready),
      .grant_id(grant_id), .busy(busy)
   );

   // source generators
   logic          src_valid[N];
   logic          src_last[N];
   logic [DW-1:0] src_data[N];
   logic [KW-1:0] src_strb[N], src_keep[N];
   logic [UW-1:0] src_user[N];
   int            src_beat[N], src_len[N], fix_len[N], pkt_left[N], seq[N];
   int            vprob = 100, rprob = 100, force_rdy = 1;

   // reference model: packet ownership, pointer, one-deep output stage
   bit            md_pass;
   int            md_owner, md_ptr, acc_port;
   bit            st_v, st_last;
   logic [DW-1:0] st_data;
   logic [KW-1:0] st_strb, st_keep;
   logic [UW-1:0] st_user;

   // scoreboard
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] out_q[$];
   int            out_cyc[$];
   int            n_cmp = 0, n_err = 0, cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      md_pass = 0; md_owner = 0; md_ptr = 0; acc_port = -1;
      st_v = 0; st_last = 0; st_data = '0; st_strb = '0; st_keep = '0; st_user = '0;
      exp_q.delete();
   endtask

   function automatic int winner();
      int start;
`ifdef AXIS_ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = md_ptr;
`endif
      for (int k = 0; k < N; k++)
         if (s_tvalid[(start + k) % N]) return (start + k) % N;
      return -1;
   endfunction

   task automatic model_eval();
      acc_port = -1;
      if (!md_pass) begin
         if (|s_tvalid) begin
            md_owner = winner();
            md_pass  = 1;
         end
         if (m_tready) st_v = 0;
      end else if (src_valid[md_owner] && (!st_v || m_tready)) begin
         st_v = 1; st_data = src_data[md_owner]; st_strb = src_strb[md_owner];
         st_keep = src_keep[md_owner]; st_user = src_user[md_owner]; st_last = src_last[md_owner];
         exp_q.push_back(src_data[md_owner]);
         acc_port = md_owner;
         if (st_last) begin
            md_pass = 0;
`ifndef AXIS_ARB_FIXED_PRIO_EN
            md_ptr = (md_owner + 1) % N;
`endif
         end
      end else if (m_tready) begin
         st_v = 0;
      end
   endtask

   task automatic gen_update();
      for (int i = 0; i < N; i++) begin
         if (!rst_n) begin
            src_valid[i] = 0; src_beat[i] = 0; src_last[i] = 0;
         end else begin
            if (acc_port == i) begin
               src_valid[i] = 0;
               if (src_last[i]) src_beat[i] = 0; else src_beat[i]++;
            end
            if (!src_valid[i] && (src_beat[i] != 0 || pkt_left[i] != 0) &&
                $urandom_range(1, 100) <= vprob) begin
               if (src_beat[i] == 0) begin
                  src_len[i] = (fix_len[i] != 0) ? fix_len[i] : int'($urandom_range(1, 4));
                  if (pkt_left[i] > 0) pkt_left[i]--;
               end
               src_valid[i] = 1;
               src_data[i]  = {i[3:0], seq[i][27:0]};
               seq[i]++;
               src_strb[i]  = KW'($urandom);
               src_keep[i]  = KW'($urandom);
               src_user[i]  = UW'($urandom);
               src_last[i]  = (src_beat[i] == src_len[i] - 1);
            end
         end
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         s_tvalid[i]            = src_valid[i];
         s_tlast[i]             = src_valid[i] ? src_last[i] : 1'b0;
         s_tdata[i*DW +: DW]    = src_data[i];
         s_tstrb[i*KW +: KW]    = src_strb[i];
         s_tkeep[i*KW +: KW]    = src_keep[i];
         s_tuser[i*UW +: UW]    = src_user[i];
      end
   endtask

   // one compare per cycle, half a period after the active edge
   task automatic check();
      logic [N-1:0] exp_rdy;
      exp_rdy = '0;
      if (md_pass && (!st_v || m_tready)) exp_rdy[md_owner] = 1'b1;
      chk("s_tready", s_tready, exp_rdy);
      chk("m_tvalid", m_tvalid, st_v);
      chk("grant_id", grant_id, md_owner);
      chk("busy", busy, md_pass || st_v);
      if (st_v || !rst_n) begin
         chk("m_tdata", m_tdata, st_data);
         chk("m_tstrb", m_tstrb, st_strb);
         chk("m_tkeep", m_tkeep, st_keep);
         chk("m_tuser", m_tuser, st_user);
         chk("m_tlast", m_tlast, st_last);
      end
      if (rst_n && m_tvalid && m_tready) begin
         if (exp_q.size() == 0) chk("sb_unexpected_beat", 1, 0);
         else chk("sb_order", m_tdata, exp_q.pop_front());
         out_q.push_back(m_tdata);
         out_cyc.push_back(cyc);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      rst_n = rst_drv;
      gen_update();
      m_tready = (force_rdy >= 0) ? (force_rdy != 0) : ($urandom_range(1, 100) <= rprob);
      drive();
      #1;
      if (!rst_n) model_reset();
      check();
      if (rst_n) model_eval(); else acc_port = -1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic clear_log();
      out_q.delete();
      out_cyc.delete();
   endtask

   int            base, first_port;
   int            rr_exp[4];
   logic [DW-1:0] hold_v;
   bit            found;

   initial begin
      for (int i = 0; i < N; i++) begin
         src_valid[i] = 0; src_last[i] = 0; src_data[i] = '0; src_strb[i] = '0;
         src_keep[i] = '0; src_user[i] = '0; src_beat[i] = 0; src_len[i] = 1;
         fix_len[i] = 0; pkt_left[i] = 0; seq[i] = 0;
      end
      model_reset();

      // reset values
      run(3);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_busy", busy, 0);
      rst_drv = 1'b1;
      run(2);

      // single 3-beat packet from port 2: A0 shows on the third cycle
      fix_len[2] = 3; pkt_left[2] = 1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (k == 1) chk("lit_first_s_tready", s_tready, 4'b0100);
         if (k == 2) begin
            chk("lit_A0_valid", m_tvalid, 1);
            chk("lit_A0", m_tdata, 32'h2000_0000);
            chk("lit_grant2", grant_id, 2);
         end
         if (k == 3) chk("lit_A1_last", m_tlast, 0);
         if (k == 4) begin
            chk("lit_A2", m_tdata, 32'h2000_0002);
            chk("lit_A2_last", m_tlast, 1);
         end
      end

      // pointer now past port 2: ports 1 and 2 together, port 1 must win
      fix_len[1] = 1; fix_len[2] = 1; pkt_left[1] = 1; pkt_left[2] = 1;
      cycle();
      cycle();
      chk("lit_wrap_grant1", grant_id, 1);
      run(8);

      // ports 0 and 1 streaming single-beat packets
      clear_log();
      fix_len[0] = 1; pkt_left[0] = -1; pkt_left[1] = -1;
      run(16);
      pkt_left[0] = 0; pkt_left[1] = 0;
      run(12);
`ifdef AXIS_ARB_FIXED_PRIO_EN
      rr_exp = '{0, 0, 0, 0};
`else
      rr_exp = '{0, 1, 0, 1};
`endif
      for (int k = 0; k < 4; k++)
         chk("lit_rr_order", (k < out_q.size()) ? out_q[k][31:28] : 4'hF, rr_exp[k]);

      // 4-beat packet from port 0, stall while beat 2 sits in the stage
      clear_log();
      base = seq[0];
      fix_len[0] = 4; pkt_left[0] = 1;
      hold_v = {4'd0, 28'(base + 1)};
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         cycle();
         if (st_v && st_data == hold_v) found = 1;
      end
      chk("bp_reached_beat2", found, 1);
      force_rdy = 0;
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("bp_hold_data", m_tdata, hold_v);
         chk("bp_hold_valid", m_tvalid, 1);
         chk("bp_owner_ready", s_tready[0], 0);
      end
      force_rdy = 1;
      run(8);
      chk("bp_count", out_q.size(), 4);
      for (int k = 0; k < 4; k++)
         chk("bp_seq", (k < out_q.size()) ? out_q[k] : '0, {4'd0, 28'(base + k)});

      // port 3 mid-packet; port 0 must wait for tlast plus one arbitration cycle
      clear_log();
      fix_len[3] = 5; pkt_left[3] = 1; fix_len[0] = 1;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         cycle();
         if (acc_port == 3 && src_beat[3] == 1) found = 1;
      end
      chk("np_reached_beat1", found, 1);
      pkt_left[0] = 1;
      run(16);
      chk("np_count", out_q.size(), 6);
      if (out_q.size() == 6) begin
         first_port = out_q[5][31:28];
         chk("np_p3_last", out_q[4][31:28], 3);
         chk("np_p0_after", first_port, 0);
         chk("np_gap", out_cyc[5] - out_cyc[4], 2);
      end

      // random traffic with a mid-packet reset
      fix_len = '{0, 0, 0, 0};
      pkt_left = '{-1, -1, -1, -1};
      vprob = 60; rprob = 70; force_rdy = -1;
      run(700);
      found = 0;
      for (int k = 0; k < 60 && !found; k++) begin
         cycle();
         if (md_pass && st_v) found = 1;
      end
      chk("rst_mid_packet_seen", found, 1);
      rst_drv = 1'b0;
      run(2);
      chk("rst_mid_valid", m_tvalid, 0);
      chk("rst_mid_busy", busy, 0);
      rst_drv = 1'b1;
      run(800);

      // drain
      pkt_left = '{0, 0, 0, 0};
      vprob = 100; force_rdy = 1;
      run(60);
      chk("drain_sb_empty", exp_q.size(), 0);
      chk("drain_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
